fc_layer_argmax: RTL and testbench

Fully connected output layer of the digit classifier, directly downstream of the pooling-2 output memory. Sweeps the 12 channels × 4×4 pooled feature map once per class against a weight ROM and accumulates 10 class scores with one signed MAC. Selects the highest score and reports the recognised digit with a sticky done flag. Drives its own P2 memory and weight ROM addresses; both memories are synchronous with 1-cycle read latency.

---
 rtl/fc_pkg.sv | 26 ++
 rtl/fc_mac.sv | 77 +++++++
 rtl/fc_layer_argmax.sv | 167 ++++++++++++++++
 tb/tb_fc_layer_argmax.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// fc_pkg: shared constants, widths and FSM state type for the fully
// connected output layer (fc_layer_argmax) and its MAC datapath (fc_mac).
package fc_pkg;

  localparam int N_CLASS = 10;
  localparam int N_CHAN  = 12;
  localparam int N_PIX   = 16;
  localparam int FEAT    = N_CHAN * N_PIX;

  localparam int CHAN_W  = 4;
  localparam int PIX_W   = 4;
  localparam int CLS_W   = 4;
  localparam int WADDR_W = 11;

  localparam logic [PIX_W-1:0]   PIX_LAST   = PIX_W'(N_PIX - 1);
  localparam logic [CHAN_W-1:0]  CHAN_LAST  = CHAN_W'(N_CHAN - 1);
  localparam logic [CLS_W-1:0]   CLS_LAST   = CLS_W'(N_CLASS - 1);
  localparam logic [WADDR_W-1:0] WADDR_LAST = WADDR_W'(N_CLASS * FEAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fc_mac.sv
// fc_mac: signed multiply-accumulate over one class sweep, then
// compare-and-keep-best at the end of each class.
// Ports:
//   clk, reset     - clock, async active-low reset
//   clear          - start of a new run: drop best score and digit
//   valid          - operands on p2_data/w_data belong to an issued address
//   first / last   - first / last product of the current class
//   cls            - class index of the product
//   p2_data/w_data - signed activation and weight
//   digit          - class index of the highest score so far
module fc_mac
  import fc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int W_W    = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              valid,
  input  logic              first,
  input  logic              last,
  input  logic [CLS_W-1:0]  cls,
  input  logic [DATA_W-1:0] p2_data,
  input  logic [W_W-1:0]    w_data,
  output logic [CLS_W-1:0]  digit
);

  localparam int PROD_W = DATA_W + W_W;

  logic [PROD_W-1:0] a_ext, b_ext, prod;
  logic [ACC_W-1:0]  prod_ext, sum;
  logic [ACC_W-1:0]  acc_q, acc_d, best_q, best_d;
  logic [CLS_W-1:0]  digit_q, digit_d;

  always_comb begin
    // Both operands sign-extended to the full product width; the low
    // PROD_W bits of the unsigned product are then the exact signed product.
    a_ext    = {{W_W{p2_data[DATA_W-1]}}, p2_data};
    b_ext    = {{DATA_W{w_data[W_W-1]}}, w_data};
    prod     = a_ext * b_ext;
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    sum      = (first ? '0 : acc_q) + prod_ext;

    acc_d   = acc_q;
    best_d  = best_q;
    digit_d = digit_q;
    if (clear) begin
      acc_d   = '0;
      best_d  = '0;
      digit_d = '0;
    end else if (valid) begin
      acc_d = sum;
      // Strict compare: a tie keeps the earlier (lower) class.
      if (last && (cls == '0 || $signed(sum) > $signed(best_q))) begin
        best_d  = sum;
        digit_d = cls;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q   <= '0;
      best_q  <= '0;
      digit_q <= '0;
    end else begin
      acc_q   <= acc_d;
      best_q  <= best_d;
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule

// File: rtl/fc_layer_argmax.sv
// fc_layer_argmax: sweeps 10 classes x 12 channels x 16 pixels against the
// weight ROM, accumulates one score per class and reports the argmax digit.
// Ports:
//   clk, reset        - clock, async active-low reset
//   start             - begin a run (honoured in IDLE or DONE)
//   enable            - low stalls address issue
//   p2_data, w_data   - memory read data, one cycle after the address
//   p2_chan, p2_addr  - pooled map bank and pixel address
//   w_addr            - weight ROM address (class*192 + chan*16 + pix)
//   busy, done, digit - run status and winning class
module fc_layer_argmax
  import fc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int W_W    = 8,
  parameter int ACC_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               enable,
  input  logic [DATA_W-1:0]  p2_data,
  input  logic [W_W-1:0]     w_data,
  output logic [CHAN_W-1:0]  p2_chan,
  output logic [PIX_W-1:0]   p2_addr,
  output logic [WADDR_W-1:0] w_addr,
  output logic               busy,
  output logic               done,
  output logic [CLS_W-1:0]   digit
);

  state_e state_q;
  logic   busy_q, done_q;

  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [CHAN_W-1:0]  chan_q, chan_d;
  logic [CLS_W-1:0]   cls_q, cls_d;
  logic [WADDR_W-1:0] waddr_q, waddr_d;
  logic               drained_q, drained_d;

  logic               s1_valid_q, s1_valid_d;
  logic               s1_first_q, s1_first_d;
  logic               s1_last_q, s1_last_d;
  logic [CLS_W-1:0]   s1_cls_q, s1_cls_d;

  logic go, issue, final_acc;

  assign go        = start && (state_q != ST_RUN);
  // drained marks that the final address has been issued; counters then hold.
  assign issue     = (state_q == ST_RUN) && enable && !drained_q;
  assign final_acc = s1_valid_q && s1_last_q && (s1_cls_q == CLS_LAST);

  always_comb begin
    pix_d     = pix_q;
    chan_d    = chan_q;
    cls_d     = cls_q;
    waddr_d   = waddr_q;
    drained_d = drained_q;
    if (go) begin
      pix_d     = '0;
      chan_d    = '0;
      cls_d     = '0;
      waddr_d   = '0;
      drained_d = 1'b0;
    end else if (issue) begin
      if (waddr_q == WADDR_LAST) begin
        drained_d = 1'b1;
      end else begin
        waddr_d = waddr_q + 1'b1;
        if (pix_q == PIX_LAST) begin
          pix_d = '0;
          if (chan_q == CHAN_LAST) begin
            chan_d = '0;
            cls_d  = cls_q + 1'b1;
          end else begin
            chan_d = chan_q + 1'b1;
          end
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
    end

    s1_valid_d = issue;
    s1_first_d = issue && (pix_q == '0) && (chan_q == '0);
    s1_last_d  = issue && (pix_q == PIX_LAST) && (chan_q == CHAN_LAST);
    s1_cls_d   = cls_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_q      <= '0;
      chan_q     <= '0;
      cls_q      <= '0;
      waddr_q    <= '0;
      drained_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_cls_q   <= '0;
    end else begin
      pix_q      <= pix_d;
      chan_q     <= chan_d;
      cls_q      <= cls_d;
      waddr_q    <= waddr_d;
      drained_q  <= drained_d;
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_cls_q   <= s1_cls_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (final_acc) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  fc_mac #(
    .DATA_W (DATA_W),
    .W_W    (W_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clear   (go),
    .valid   (s1_valid_q),
    .first   (s1_first_q),
    .last    (s1_last_q),
    .cls     (s1_cls_q),
    .p2_data (p2_data),
    .w_data  (w_data),
    .digit   (digit)
  );

  assign p2_chan = chan_q;
  assign p2_addr = pix_q;
  assign w_addr  = waddr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_fc_layer_argmax.sv
module tb_fc_layer_argmax;
  import fc_pkg::*;

  localparam int DATA_W = 16;
  localparam int W_W    = 8;
  localparam int ACC_W  = 32;
  localparam int NW     = N_CLASS * FEAT;
  localparam int LIMIT  = 8000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic enable = 1'b0;
  logic [DATA_W-1:0] p2_data = '0;
  logic [W_W-1:0]    w_data = '0;
  logic [3:0]  p2_chan, p2_addr, digit;
  logic [10:0] w_addr;
  logic        busy, done;

  logic signed [15:0] p2_mem [N_CHAN][N_PIX];
  logic signed [7:0]  w_rom [NW];
  bit en_rand [LIMIT+2];

  int checks = 0;
  int failures = 0;

  typedef struct {
    int pat;
    int en_mode;
    int restart_k;
    int exp_digit;
  } vec_t;
  vec_t vecs [9];

  fc_layer_argmax #(.DATA_W(DATA_W), .W_W(W_W), .ACC_W(ACC_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .enable  (enable),
    .p2_data (p2_data),
    .w_data  (w_data),
    .p2_chan (p2_chan),
    .p2_addr (p2_addr),
    .w_addr  (w_addr),
    .busy    (busy),
    .done    (done),
    .digit   (digit)
  );

  always #5 clk = ~clk;

  // Synchronous memories, one-cycle read latency.
  always @(posedge clk) begin
    p2_data <= p2_mem[int'(p2_chan) % N_CHAN][int'(p2_addr)];
    w_data  <= w_rom[int'(w_addr) % NW];
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fill_mem(input int pat);
    for (int ch = 0; ch < N_CHAN; ch++)
      for (int px = 0; px < N_PIX; px++) begin
        case (pat)
          0: p2_mem[ch][px] = 16'($urandom);
          1: p2_mem[ch][px] = 16'sd1;
          2: p2_mem[ch][px] = 16'($urandom_range(0, 100));
          3: p2_mem[ch][px] = 16'sd100;
          4: p2_mem[ch][px] = 16'h7FFF;
          default: p2_mem[ch][px] = 16'($urandom);
        endcase
      end
    for (int c = 0; c < N_CLASS; c++)
      for (int j = 0; j < FEAT; j++) begin
        case (pat)
          0: w_rom[c*FEAT+j] = 8'sd0;
          1: w_rom[c*FEAT+j] = (c == 7) ? 8'sd1 : 8'sd0;
          2: w_rom[c*FEAT+j] = (c == 3 || c == 5) ? 8'sd127 : 8'($urandom_range(0, 126));
          3: w_rom[c*FEAT+j] = 8'(c - 10);
          4: w_rom[c*FEAT+j] = (c == 2) ? 8'h7F : 8'h80;
          default: w_rom[c*FEAT+j] = 8'($urandom);
        endcase
      end
  endtask

  // Reference: plain dot products and an argmax with lowest-index tie-break.
  task automatic model(output int exp_digit, output int exp_best);
    int s;
    exp_digit = 0;
    exp_best  = 0;
    for (int c = 0; c < N_CLASS; c++) begin
      s = 0;
      for (int ch = 0; ch < N_CHAN; ch++)
        for (int px = 0; px < N_PIX; px++)
          s += int'(p2_mem[ch][px]) * int'(w_rom[c*FEAT + ch*N_PIX + px]);
      if (c == 0 || s > exp_best) begin
        exp_best  = s;
        exp_digit = c;
      end
    end
  endtask

  function automatic bit en_for(input int mode, input int k);
    case (mode)
      0: return 1'b1;
      1: return (k % 2) == 1;
      default: return en_rand[k];
    endcase
  endfunction

  // Cycles from the start edge to done: one more than the edge of the last issue.
  function automatic int exp_cycles(input int mode);
    int issued = 0;
    int k = 0;
    while (issued < NW && k < LIMIT) begin
      k++;
      if (en_for(mode, k)) issued++;
    end
    return k + 1;
  endfunction

  task automatic do_run(input int mode, input int restart_k,
                        output int cyc, output logic [1:0] start_bd,
                        output bit hold_ok, output bit trace_ok);
    int k;
    int tw [32];
    int tc [32];
    logic [3:0]  pa, pc;
    logic [10:0] wa;
    enable = 1'b1;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    start_bd = {busy, done};
    cyc      = 0;
    hold_ok  = 1'b1;
    while (cyc < LIMIT) begin
      k = cyc + 1;
      if (cyc < 32) begin
        tw[cyc] = int'(w_addr);
        tc[cyc] = int'(p2_chan);
      end
      enable = en_for(mode, k);
      start  = (k == restart_k);
      pa = p2_addr;
      pc = p2_chan;
      wa = w_addr;
      @(posedge clk);
      #1;
      cyc   = k;
      start = 1'b0;
      if (!enable && (p2_addr != pa || p2_chan != pc || w_addr != wa)) hold_ok = 1'b0;
      if (done) break;
    end
    enable   = 1'b1;
    trace_ok = (tc[15] == 0) && (tc[16] == 1);
    for (int i = 0; i < 32; i++)
      if (tw[i] != i) trace_ok = 1'b0;
  endtask

  initial begin
    int ed, eb, ec, cyc;
    logic [1:0] bd;
    bit hold_ok, trace_ok;

    vecs[0] = '{0, 0, -1, 0};
    vecs[1] = '{1, 0, -1, 7};
    vecs[2] = '{2, 0, -1, 3};
    vecs[3] = '{3, 0, -1, 9};
    vecs[4] = '{4, 0, -1, 2};
    vecs[5] = '{5, 0, -1, -1};
    vecs[6] = '{2, 1, -1, 3};
    vecs[7] = '{5, 2, -1, -1};
    vecs[8] = '{1, 0, 100, 7};

    #2 reset = 1'b0;
    #1;
    check("reset_outputs", {p2_chan, p2_addr, w_addr, busy, done, digit}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      fill_mem(vecs[i].pat);
      for (int k = 0; k < LIMIT + 2; k++) en_rand[k] = ($urandom_range(0, 3) != 0);
      model(ed, eb);
      if (vecs[i].exp_digit >= 0) ed = vecs[i].exp_digit;
      ec = exp_cycles(vecs[i].en_mode);
      do_run(vecs[i].en_mode, vecs[i].restart_k, cyc, bd, hold_ok, trace_ok);
      check($sformatf("v%0d_busy_done_at_start", i), bd, 2);
      check($sformatf("v%0d_done_cycle", i), cyc, ec);
      check($sformatf("v%0d_digit", i), digit, ed);
      check($sformatf("v%0d_best", i), longint'($signed(dut.u_mac.best_q)), eb);
      check($sformatf("v%0d_busy_after", i), {busy, done}, 1);
      if (vecs[i].en_mode != 0)
        check($sformatf("v%0d_addr_hold", i), hold_ok, 1);
      if (vecs[i].pat == 1 && vecs[i].en_mode == 0 && vecs[i].restart_k < 0)
        check($sformatf("v%0d_addr_trace", i), trace_ok, 1);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("v%0d_done_sticky", i), {done, digit}, {1'b1, 4'(ed)});
    end

    // Reset in the middle of a run, then a clean run afterwards.
    fill_mem(5);
    model(ed, eb);
    enable = 1'b1;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (500) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("midrun_reset_outputs", {p2_chan, p2_addr, w_addr, busy, done, digit}, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    do_run(0, -1, cyc, bd, hold_ok, trace_ok);
    check("after_reset_done_cycle", cyc, 1921);
    check("after_reset_digit", digit, ed);
    check("after_reset_best", longint'($signed(dut.u_mac.best_q)), eb);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
